// File: rtl/ad_scan_scheduler_pkg.sv
// Shared types and constants for the AD scan scheduler: FSM encoding,
// UART frame layout and the data value recorded for a timed-out conversion.
package ad_scan_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_START = 3'd2,
    ST_CONV  = 3'd3,
    ST_TX_HI = 3'd4,
    ST_TX_LO = 3'd5,
    ST_NEXT  = 3'd6
  } state_t;

  // First byte of a frame: channel in the upper nibble, result MSBs below.
  typedef struct packed {
    logic [3:0] ch;
    logic [3:0] data_hi;
  } frame_hi_t;

  localparam logic [11:0] TIMEOUT_DATA = 12'hFFF;

endpackage

// File: rtl/ad_scan_scheduler_if.sv
// Converter handshake (AD_Top) and byte stream (Uart_Top) seen by the scheduler.
interface ad_scan_scheduler_if;
  logic        AD_Start;
  logic [3:0]  AD_Address;
  logic        AD_Done;
  logic [11:0] AD_Data;
  logic [7:0]  Tx_Data;
  logic        Tx_Valid;
  logic        Tx_Ready;

  modport master (
    output AD_Start, AD_Address, Tx_Data, Tx_Valid,
    input  AD_Done, AD_Data, Tx_Ready
  );

  modport slave (
    input  AD_Start, AD_Address, Tx_Data, Tx_Valid,
    output AD_Done, AD_Data, Tx_Ready
  );
endinterface

// File: rtl/ad_scan_tick.sv
// Scan-rate prescaler: counts 0..SCAN_DIV-1 while enabled and pulses o_tick
// for one cycle at the terminal count.
module ad_scan_tick #(
  parameter int SCAN_DIV = 50000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  output logic o_tick
);
  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [CW-1:0] r_cnt;
  logic          w_last;

  assign w_last = (r_cnt == CW'(SCAN_DIV - 1));
  assign o_tick = i_en & w_last;

  // Count holds its value while disabled rather than restarting.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_last ? '0 : r_cnt + CW'(1);
    end
  end
endmodule

// File: rtl/ad_scan_scheduler.sv
// Scans masked AD channels on each tick, keeps the latest result per channel
// and, with AD_SCAN_UART_EN defined, streams each result as a 2-byte frame.
module ad_scan_scheduler
  import ad_scan_scheduler_pkg::*;
#(
  parameter int NUM_CH       = 8,
  parameter int SCAN_DIV     = 50000,
  parameter int CONV_TIMEOUT = 1024
) (
  input  logic              Sys_CLK,
  input  logic              Sys_RST,
  input  logic              Scan_En,
  input  logic [NUM_CH-1:0] Ch_Mask,
  input  logic              Err_Clr,
  input  logic [3:0]        Rd_Addr,
  output logic [11:0]       Rd_Data,
  output logic              Scan_Busy,
  output logic              Timeout_Err,
  output logic              Overrun_Err,
  ad_scan_scheduler_if.master bus
);
  localparam int         TO_W     = $clog2(CONV_TIMEOUT + 1);
  localparam logic [4:0] CH_LIMIT = 5'(NUM_CH);

  state_t      r_state, w_state_next;
  logic [3:0]  r_ch;
  logic [15:0] r_mask;
  logic [11:0] r_data;
  logic [TO_W-1:0] r_to_cnt;
  logic        r_timeout_err, r_overrun_err;
  logic [11:0] r_rd_data;
  logic [11:0] r_bank [16];

  logic        w_tick;
  logic [15:0] w_mask_in;
  logic        w_first_found, w_next_found;
  logic [3:0]  w_first_ch, w_next_ch;
  logic        w_timeout, w_conv_done, w_scan_start, w_ch_advance, w_overrun;
  logic [11:0] w_conv_data;
  logic        w_ad_start, w_tx_valid;
  logic [7:0]  w_tx_data;

  ad_scan_tick #(.SCAN_DIV(SCAN_DIV)) u_tick (
    .i_clk   (Sys_CLK),
    .i_rst_n (Sys_RST),
    .i_en    (Scan_En),
    .o_tick  (w_tick)
  );

  // Lowest set bit of the live mask, and next set bit above r_ch in the latched mask.
  always_comb begin
    w_mask_in               = '0;
    w_mask_in[NUM_CH-1:0]   = Ch_Mask;
    w_first_found           = 1'b0;
    w_first_ch              = '0;
    w_next_found            = 1'b0;
    w_next_ch               = '0;
    for (int i = 15; i >= 0; i--) begin
      if (w_mask_in[i]) begin
        w_first_found = 1'b1;
        w_first_ch    = 4'(i);
      end
      if (r_mask[i] && (4'(i) > r_ch)) begin
        w_next_found = 1'b1;
        w_next_ch    = 4'(i);
      end
    end
  end

  assign w_timeout    = (r_state == ST_CONV) && !bus.AD_Done &&
                        (r_to_cnt == TO_W'(CONV_TIMEOUT - 1));
  assign w_conv_done  = (r_state == ST_CONV) && (bus.AD_Done || w_timeout);
  assign w_conv_data  = bus.AD_Done ? bus.AD_Data : TIMEOUT_DATA;
  assign w_scan_start = (r_state == ST_WAIT) && Scan_En && w_tick && w_first_found;
  assign w_ch_advance = (r_state == ST_NEXT) && Scan_En && w_next_found;
  assign w_overrun    = w_tick && Scan_Busy;

  always_ff @(posedge Sys_CLK or negedge Sys_RST) begin
    if (!Sys_RST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (Scan_En) w_state_next = ST_WAIT;
      ST_WAIT: begin
        if (!Scan_En)         w_state_next = ST_IDLE;
        else if (w_scan_start) w_state_next = ST_START;
      end
      ST_START: w_state_next = ST_CONV;
      ST_CONV: begin
`ifdef AD_SCAN_UART_EN
        if (w_conv_done) w_state_next = ST_TX_HI;
`else
        if (w_conv_done) w_state_next = ST_NEXT;
`endif
      end
      ST_TX_HI: if (bus.Tx_Ready) w_state_next = ST_TX_LO;
      ST_TX_LO: if (bus.Tx_Ready) w_state_next = ST_NEXT;
      ST_NEXT: begin
        if (!Scan_En)          w_state_next = ST_IDLE;
        else if (w_ch_advance) w_state_next = ST_START;
        else                   w_state_next = ST_WAIT;
      end
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_ad_start = (r_state == ST_START);
    Scan_Busy  = (r_state != ST_IDLE) && (r_state != ST_WAIT);
    w_tx_valid = 1'b0;
    w_tx_data  = '0;
`ifdef AD_SCAN_UART_EN
    if (r_state == ST_TX_HI) begin
      w_tx_valid = 1'b1;
      w_tx_data  = frame_hi_t'{ch: r_ch, data_hi: r_data[11:8]};
    end else if (r_state == ST_TX_LO) begin
      w_tx_valid = 1'b1;
      w_tx_data  = r_data[7:0];
    end
`endif
  end

`ifndef AD_SCAN_UART_EN
  logic [12:0] w_unused_tx;
  assign w_unused_tx = {bus.Tx_Ready, r_data};
`endif

  // New error events take priority over a simultaneous Err_Clr.
  always_ff @(posedge Sys_CLK or negedge Sys_RST) begin
    if (!Sys_RST) begin
      r_ch          <= '0;
      r_mask        <= '0;
      r_data        <= '0;
      r_to_cnt      <= '0;
      r_timeout_err <= 1'b0;
      r_overrun_err <= 1'b0;
      r_rd_data     <= '0;
      for (int i = 0; i < 16; i++) r_bank[i] <= '0;
    end else begin
      if (w_scan_start) begin
        r_mask <= w_mask_in;
        r_ch   <= w_first_ch;
      end else if (w_ch_advance) begin
        r_ch   <= w_next_ch;
      end
      r_to_cnt <= (r_state == ST_CONV) ? r_to_cnt + TO_W'(1) : '0;
      if (w_conv_done) begin
        r_bank[r_ch] <= w_conv_data;
        r_data       <= w_conv_data;
      end
      if (w_timeout)    r_timeout_err <= 1'b1;
      else if (Err_Clr) r_timeout_err <= 1'b0;
      if (w_overrun)    r_overrun_err <= 1'b1;
      else if (Err_Clr) r_overrun_err <= 1'b0;
      r_rd_data <= ({1'b0, Rd_Addr} < CH_LIMIT) ? r_bank[Rd_Addr] : '0;
    end
  end

  assign bus.AD_Start   = w_ad_start;
  assign bus.AD_Address = r_ch;
  assign bus.Tx_Valid   = w_tx_valid;
  assign bus.Tx_Data    = w_tx_data;
  assign Rd_Data        = r_rd_data;
  assign Timeout_Err    = r_timeout_err;
  assign Overrun_Err    = r_overrun_err;
endmodule
